// File: rtl/cla_pipe_adder64.sv
// cla_pipe_adder64 -- two-stage pipelined wide adder built from 16-bit
// carry-lookahead slices.
//   Stage 1 adds the low WIDTH/2 bits and registers the carry into the high half
//   together with the high operand halves. Stage 2 adds the high half and
//   registers the full result, carry out, signed overflow and all-propagate flag.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake (in_ready is combinational)
//   in_a, in_b, in_cin     operands and carry in
//   out_valid/out_ready    result handshake
//   out_sum, out_cout      (a+b+cin) mod 2^WIDTH and unsigned carry out
//   out_ovf, out_pm        signed overflow and "every bit propagates" flag
// Also contains carry_ahead_adder16, the 16-bit slice used by both stages.

// carry_ahead_adder16 -- 16-bit two-level carry-lookahead adder.
// Ports: a, b, cin in; sum, cout, group generate Gm, group propagate Pm out.
module carry_ahead_adder16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout,
   output logic        Gm,
   output logic        Pm
);
   logic [15:0] g_s;
   logic [15:0] p_s;
   logic [15:0] c_s;
   logic [3:0]  gg_s;
   logic [3:0]  gp_s;
   logic [3:0]  gc_s;

   assign g_s = a & b;
   assign p_s = a ^ b;

   // Generate/propagate of each 4-bit group.
   always_comb begin
      gg_s = 4'b0000;
      gp_s = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         gg_s[k] = g_s[4*k+3]
                 | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | ((&p_s[4*k+1 +: 3]) & g_s[4*k]);
         gp_s[k] = &p_s[4*k +: 4];
      end
   end

   // Second lookahead level: carries into each group straight from cin.
   assign gc_s[0] = cin;
   assign gc_s[1] = gg_s[0] | (gp_s[0] & cin);
   assign gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
   assign gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                  | (gp_s[2] & gp_s[1] & gp_s[0] & cin);

   assign Gm   = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
               | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0]);
   assign Pm   = &gp_s;
   assign cout = Gm | (Pm & cin);

   // Bit carries inside each group, expanded from the group carry in.
   always_comb begin
      c_s = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         c_s[4*k]   = gc_s[k];
         c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
         c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                    | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
         c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                    | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      end
   end

   assign sum = p_s ^ c_s;
endmodule

module cla_pipe_adder64 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_pm
);
   localparam int HALF = WIDTH / 2;
   localparam int NS   = WIDTH / 32;

   logic            s1_valid_r;
   logic            s2_valid_r;
   logic [HALF-1:0] lo_sum_r;
   logic [HALF-1:0] a_hi_r;
   logic [HALF-1:0] b_hi_r;
   logic            c_mid_r;
   logic            pm_lo_r;
   logic [WIDTH-1:0] sum_r;
   logic            cout_r;
   logic            ovf_r;
   logic            pm_r;

   logic            s1_ready_s;
   logic            in_load_s;
   logic            s1_adv_s;
   logic            out_xfer_s;
   logic [HALF-1:0] lo_sum_s;
   logic [HALF-1:0] hi_sum_s;
   logic [NS:0]     c1_s;
   logic [NS:0]     c2_s;
   logic [NS-1:0]   pm1_s;
   logic [NS-1:0]   pm2_s;
   logic [NS-1:0]   gm1_unused_s;
   logic [NS-1:0]   gm2_unused_s;
   logic            c_msb_s;

   // Handshake: no skid buffer, so readiness ripples back combinationally.
   assign s1_ready_s = !s2_valid_r || out_ready;
   assign in_ready   = rst_n && (!s1_valid_r || s1_ready_s);
   assign in_load_s  = in_valid && in_ready;
   assign s1_adv_s   = s1_valid_r && s1_ready_s;
   assign out_xfer_s = s2_valid_r && out_ready;

   assign c1_s[0] = in_cin;
   assign c2_s[0] = c_mid_r;

   for (genvar i = 0; i < NS; i++) begin : g_slice
      carry_ahead_adder16 u_lo (
         .a    (in_a[16*i +: 16]),
         .b    (in_b[16*i +: 16]),
         .cin  (c1_s[i]),
         .sum  (lo_sum_s[16*i +: 16]),
         .cout (c1_s[i+1]),
         .Gm   (gm1_unused_s[i]),
         .Pm   (pm1_s[i])
      );
      carry_ahead_adder16 u_hi (
         .a    (a_hi_r[16*i +: 16]),
         .b    (b_hi_r[16*i +: 16]),
         .cin  (c2_s[i]),
         .sum  (hi_sum_s[16*i +: 16]),
         .cout (c2_s[i+1]),
         .Gm   (gm2_unused_s[i]),
         .Pm   (pm2_s[i])
      );
   end

   // Carry into the MSB recovered from the MSB sum bit and its operands.
   assign c_msb_s = hi_sum_s[HALF-1] ^ a_hi_r[HALF-1] ^ b_hi_r[HALF-1];

   // Pipeline valid flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s2_valid_r <= 1'b0;
      end else begin
         if (in_load_s) begin
            s1_valid_r <= 1'b1;
         end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
         end
         if (s1_adv_s) begin
            s2_valid_r <= 1'b1;
         end else if (out_xfer_s) begin
            s2_valid_r <= 1'b0;
         end
      end
   end

   // Stage 1 data: low-half result, mid carry and raw high operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_sum_r <= {HALF{1'b0}};
         a_hi_r   <= {HALF{1'b0}};
         b_hi_r   <= {HALF{1'b0}};
         c_mid_r  <= 1'b0;
         pm_lo_r  <= 1'b0;
      end else if (in_load_s) begin
         lo_sum_r <= lo_sum_s;
         a_hi_r   <= in_a[WIDTH-1:HALF];
         b_hi_r   <= in_b[WIDTH-1:HALF];
         c_mid_r  <= c1_s[NS];
         pm_lo_r  <= &pm1_s;
      end
   end

   // Stage 2 data: full result, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r  <= {WIDTH{1'b0}};
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         pm_r   <= 1'b0;
      end else if (s1_adv_s) begin
         sum_r  <= {hi_sum_s, lo_sum_r};
         cout_r <= c2_s[NS];
         ovf_r  <= c_msb_s ^ c2_s[NS];
         pm_r   <= pm_lo_r & (&pm2_s);
      end
   end

   assign out_valid = s2_valid_r;
   assign out_sum   = sum_r;
   assign out_cout  = cout_r;
   assign out_ovf   = ovf_r;
   assign out_pm    = pm_r;
endmodule

// File: tb/tb_cla_pipe_adder64.sv
// Directed and random bench for cla_pipe_adder64 with a scoreboard queue.
module tb_cla_pipe_adder64;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        out_pm;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic        pm;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          n_acc    = 0;
   bit          acc;
   bit          chk_lat;
   bit          hold_v;
   logic [63:0] h_sum;
   logic        h_cout;
   logic        h_ovf;
   logic        h_pm;

   cla_pipe_adder64 #(.WIDTH(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_pm    (out_pm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic cin);
      exp_t        e;
      logic [64:0] t;
      t      = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      e.sum  = t[63:0];
      e.cout = t[64];
      e.ovf  = (a[63] == b[63]) && (t[63] != a[63]);
      e.pm   = &(a ^ b);
      e.due  = 0;
      return e;
   endfunction

   // One clock: sample at negedge, score transfers, return just after posedge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (hold_v) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_sum", out_sum, h_sum);
         chk("hold_cout", out_cout, h_cout);
         chk("hold_ovf", out_ovf, h_ovf);
         chk("hold_pm", out_pm, h_pm);
      end
      hold_v = out_valid && !out_ready;
      h_sum  = out_sum;
      h_cout = out_cout;
      h_ovf  = out_ovf;
      h_pm   = out_pm;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out", out_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("sum", out_sum, e.sum);
            chk("cout", out_cout, e.cout);
            chk("ovf", out_ovf, e.ovf);
            chk("pm", out_pm, e.pm);
            if (chk_lat) chk("latency", cyc, e.due);
         end
      end
      acc = in_valid && in_ready;
      if (acc) begin
         e     = model(in_a, in_b, in_cin);
         e.due = cyc + 2;
         sb.push_back(e);
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin);
      int n;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      n        = 0;
      do begin
         tick();
         n++;
      end while (!acc && n < 20);
      if (!acc) chk("send_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      int stall;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = 64'd0;
      in_b      = 64'd0;
      in_cin    = 1'b0;
      out_ready = 1'b1;
      chk_lat   = 1'b1;
      hold_v    = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_sum", out_sum, 64'd0);
      chk("rst_out_flags", {out_cout, out_ovf, out_pm}, 3'b000);
      chk("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1'b1);
      chk("rel_out_valid", out_valid, 1'b0);

      // Directed single adds with latency check
      send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      drain();
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      drain();
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      drain();
      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      drain();

      // Backpressure: five inputs with the consumer stalled at first
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      n_acc     = 0;
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1'b1;
         in_a     = 64'(k);
         in_b     = 64'(k) << 32;
         in_cin   = 1'b0;
         stall    = 0;
         do begin
            tick();
            if (!acc) begin
               stall++;
               if (stall == 3) begin
                  chk("bp_accepts", n_acc, 2);
                  chk("bp_in_ready", in_ready, 1'b0);
                  out_ready = 1'b1;
               end
            end
         end while (!acc && stall < 20);
         if (!acc) chk("bp_timeout", in_ready, 1'b1);
      end
      in_valid = 1'b0;
      drain();

      // Throughput: 100 random back-to-back inputs
      chk_lat   = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         in_valid = 1'b1;
         in_a     = {$urandom(), $urandom()};
         in_b     = {$urandom(), $urandom()};
         in_cin   = 1'($urandom_range(0, 1));
         tick();
         if (!acc) chk("tp_accept", in_ready, 1'b1);
      end
      in_valid = 1'b0;
      drain();

      // Asynchronous reset with two results in flight
      send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
      send(64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", out_valid, 1'b0);
      chk("ar_out_sum", out_sum, 64'd0);
      chk("ar_in_ready", in_ready, 1'b0);
      sb.delete();
      hold_v = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (4) tick();
      send(64'h0123_4567_89AB_CDEF, 64'h1111_0000_1111_0000, 1'b1);
      drain();
      repeat (3) tick();
      chk("final_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cla_pipe_adder64.md
Name: cla_pipe_adder64

Overview:
- Two-stage pipelined wide adder built from carry_ahead_adder16 slices.
- Stage 1 adds the low half and registers the carry into the high half. Stage 2 adds the high half.
- Valid/ready handshakes on both sides. Full throughput of one add per cycle; latency 2 cycles.
- Sits upstream of the datapath result bus and consumes the 16-bit CLA slices as its arithmetic core.

Parameters:
- WIDTH, 64, operand width. Must be a multiple of 32. Each pipeline stage handles WIDTH/2 bits using WIDTH/32 16-bit slices chained cout->cin.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and cin presented
- in_ready  out  1  block accepts the operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry in
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH
- out_cout  out  1  unsigned carry out of bit WIDTH-1
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- out_pm  out  1  every bit position propagates (a^b all ones). AND of all slice Pm outputs.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, all data registers 0.
  - Outputs during and after reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_pm=0.
  - in_ready=1 once rst_n is deasserted. in_ready is held 0 while rst_n is low.
- Stage 1 register captures:
  - lo_sum = a[W/2-1:0] + b[W/2-1:0] + cin
  - c_mid = carry out of the low half
  - pm_lo = AND of the low-slice Pm
  - a_hi and b_hi
- Stage 2 register captures:
  - sum = {hi_sum, lo_sum}, where hi_sum uses c_mid as carry in
  - cout = carry out of the high half
  - ovf = carry into the MSB XOR cout
  - pm = pm_lo AND high-slice Pm
- Handshake:
  - s1_ready = !s2_valid || out_ready
  - in_ready = !s1_valid || s1_ready (combinational, no skid buffer)
  - Input transfer when in_valid && in_ready: load stage 1, set s1_valid=1.
  - Stage 1 advances when s1_valid && s1_ready: load stage 2, set s2_valid=1.
  - If stage 1 advances with no new input that cycle, s1_valid goes to 0.
  - Output transfer when out_valid && out_ready. If stage 1 does not advance that cycle, s2_valid goes to 0.
- Latency and throughput:
  - An accepted input appears on out_valid exactly 2 cycles later if out_ready was held 1.
  - Back-to-back inputs give one result per cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_sum, out_cout, out_ovf and out_pm hold stable.
  - With both stages full, in_ready=0.
- Simultaneous events: output transfer, stage 1 advance and input transfer may all occur in one cycle. The pipeline stays full with no bubble and no loss.
- Results leave in input order. No reordering and no drop.
- Data registers update only on their stage's load enable. Register contents while valid=0 are don't-care for checking purposes, but the RTL must not toggle them.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only via out_cout.
- Reset mid-operation: in-flight results are discarded. No out_valid is asserted for them after reset release.
- The module may use WIDTH/16 instances of carry_ahead_adder16 (in/out a, b, cin, cout, sum, Gm, Pm). Gm is unused except for optional assertions.

Test Plan:
- Single add: a=0x0000_0000_FFFF_FFFF, b=1, cin=0, out_ready=1 -> out_valid 2 cycles later, sum=0x0000_0001_0000_0000, cout=0, ovf=0, pm=0. Exercises the stage-boundary carry.
- Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0, pm=1.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1. Also a=b=0x8000_0000_0000_0000 -> sum=0, cout=1, ovf=1.
- Backpressure: stream 5 inputs k=1..5 (a=k, b=k<<32) with out_ready=0 for cycles 2-6 -> in_ready drops after 2 accepts, outputs hold stable, all 5 results arrive in order after out_ready=1 with no duplicates.
- Throughput: 100 random back-to-back inputs with out_ready=1 -> 100 results on 100 consecutive cycles, each matching a golden a+b+cin with correct cout and ovf.
- Async reset: assert rst_n low mid-stream with 2 results in flight, asynchronously to clk -> out_valid=0 and out_sum=0 immediately. After release, the next input produces the first out_valid; the flushed items never appear.
